// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one req/gnt/rvalid RAM port between host A (instruction fetch) and
// host B (data). The winning request is forwarded to the device in the same
// cycle. An in-order ID FIFO remembers which host owns every accepted but
// unanswered transaction, so device responses are steered back to the host
// that issued them.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   a_* / b_*               host ports: req/gnt, addr/we/be/wdata,
//                           rvalid/rdata/err
//   dev_*                   shared device port
//   spurious_o              sticky: a device response arrived while nothing
//                           was outstanding
module ram_port_arbiter #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          FixedPrioB     = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   a_req_i,
  output logic                   a_gnt_o,
  input  logic [AddrWidth-1:0]   a_addr_i,
  input  logic                   a_we_i,
  input  logic [DataWidth/8-1:0] a_be_i,
  input  logic [DataWidth-1:0]   a_wdata_i,
  output logic                   a_rvalid_o,
  output logic [DataWidth-1:0]   a_rdata_o,
  output logic                   a_err_o,

  input  logic                   b_req_i,
  output logic                   b_gnt_o,
  input  logic [AddrWidth-1:0]   b_addr_i,
  input  logic                   b_we_i,
  input  logic [DataWidth/8-1:0] b_be_i,
  input  logic [DataWidth-1:0]   b_wdata_i,
  output logic                   b_rvalid_o,
  output logic [DataWidth-1:0]   b_rdata_o,
  output logic                   b_err_o,

  output logic                   dev_req_o,
  input  logic                   dev_gnt_i,
  output logic [AddrWidth-1:0]   dev_addr_o,
  output logic                   dev_we_o,
  output logic [DataWidth/8-1:0] dev_be_o,
  output logic [DataWidth-1:0]   dev_wdata_o,
  input  logic                   dev_rvalid_i,
  input  logic [DataWidth-1:0]   dev_rdata_i,
  input  logic                   dev_err_i,

  output logic                   spurious_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

  // ID 0 = host A, ID 1 = host B
  logic [MaxOutstanding-1:0] id_fifo_q;
  logic [PtrW-1:0]           wptr_q, wptr_d;
  logic [PtrW-1:0]           rptr_q, rptr_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      last_b_q, last_b_d;
  logic                      spurious_q, spurious_d;

  logic full;
  logic empty;
  logic win_b;
  logic push;
  logic pop;
  logic head_b;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  assign full  = (cnt_q == CntMax);
  assign empty = (cnt_q == '0);

  // Round-robin gives the contended slot to whoever did not win the last
  // completed handshake; a stalled request never changes the order.
  assign win_b = b_req_i & (~a_req_i | FixedPrioB | ~last_b_q);

  // full is a registered condition only, so a same-cycle rvalid cannot open
  // a grant combinationally.
  assign dev_req_o   = (a_req_i | b_req_i) & ~full;
  assign dev_addr_o  = win_b ? b_addr_i  : a_addr_i;
  assign dev_we_o    = win_b ? b_we_i    : a_we_i;
  assign dev_be_o    = win_b ? b_be_i    : a_be_i;
  assign dev_wdata_o = win_b ? b_wdata_i : a_wdata_i;

  assign push = dev_req_o & dev_gnt_i;
  assign pop  = dev_rvalid_i & ~empty;

  assign a_gnt_o = push & ~win_b;
  assign b_gnt_o = push &  win_b;

  // Responses pass straight through to the owner of the oldest entry.
  assign head_b     = id_fifo_q[rptr_q];
  assign a_rvalid_o = pop & ~head_b;
  assign b_rvalid_o = pop &  head_b;
  assign a_err_o    = pop & ~head_b & dev_err_i;
  assign b_err_o    = pop &  head_b & dev_err_i;
  assign a_rdata_o  = dev_rdata_i;
  assign b_rdata_o  = dev_rdata_i;

  assign spurious_o = spurious_q;

  always_comb begin
    wptr_d     = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d     = pop  ? ptr_inc(rptr_q) : rptr_q;
    last_b_d   = push ? win_b : last_b_q;
    spurious_d = spurious_q | (dev_rvalid_i & empty);
    cnt_d      = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      last_b_q   <= 1'b1;
      spurious_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      last_b_q   <= last_b_d;
      spurious_q <= spurious_d;
    end
  end

  // Entries are only read when the count says they are valid, so the
  // storage itself needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_fifo_q[wptr_q] <= win_b;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [AW-1:0] A_ADDR  = 32'hA000_0010;
  localparam logic [AW-1:0] B_ADDR  = 32'hB000_0020;
  localparam logic [DW-1:0] A_WDATA = 32'h1111_AAAA;
  localparam logic [DW-1:0] B_WDATA = 32'h2222_BBBB;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic a_req, b_req, dev_gnt, dev_rvalid, dev_err;
  logic [DW-1:0] dev_rdata;

  // DUT0: round-robin; DUT1: fixed priority B. Inputs are shared.
  logic d0_a_gnt, d0_b_gnt, d0_a_rv, d0_b_rv, d0_a_err, d0_b_err, d0_req, d0_we, d0_spur;
  logic [DW-1:0] d0_a_rdata, d0_b_rdata, d0_wdata;
  logic [AW-1:0] d0_addr;
  logic [DW/8-1:0] d0_be;
  logic d1_a_gnt, d1_b_gnt, d1_a_rv, d1_b_rv, d1_a_err, d1_b_err, d1_req, d1_we, d1_spur;
  logic [DW-1:0] d1_a_rdata, d1_b_rdata, d1_wdata;
  logic [AW-1:0] d1_addr;
  logic [DW/8-1:0] d1_be;

  ram_port_arbiter #(.AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(2), .FixedPrioB(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(a_req), .a_gnt_o(d0_a_gnt), .a_addr_i(A_ADDR), .a_we_i(1'b0), .a_be_i(4'hF),
    .a_wdata_i(A_WDATA), .a_rvalid_o(d0_a_rv), .a_rdata_o(d0_a_rdata), .a_err_o(d0_a_err),
    .b_req_i(b_req), .b_gnt_o(d0_b_gnt), .b_addr_i(B_ADDR), .b_we_i(1'b1), .b_be_i(4'h3),
    .b_wdata_i(B_WDATA), .b_rvalid_o(d0_b_rv), .b_rdata_o(d0_b_rdata), .b_err_o(d0_b_err),
    .dev_req_o(d0_req), .dev_gnt_i(dev_gnt), .dev_addr_o(d0_addr), .dev_we_o(d0_we),
    .dev_be_o(d0_be), .dev_wdata_o(d0_wdata), .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata),
    .dev_err_i(dev_err), .spurious_o(d0_spur)
  );

  ram_port_arbiter #(.AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(2), .FixedPrioB(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(a_req), .a_gnt_o(d1_a_gnt), .a_addr_i(A_ADDR), .a_we_i(1'b0), .a_be_i(4'hF),
    .a_wdata_i(A_WDATA), .a_rvalid_o(d1_a_rv), .a_rdata_o(d1_a_rdata), .a_err_o(d1_a_err),
    .b_req_i(b_req), .b_gnt_o(d1_b_gnt), .b_addr_i(B_ADDR), .b_we_i(1'b1), .b_be_i(4'h3),
    .b_wdata_i(B_WDATA), .b_rvalid_o(d1_b_rv), .b_rdata_o(d1_b_rdata), .b_err_o(d1_b_err),
    .dev_req_o(d1_req), .dev_gnt_i(dev_gnt), .dev_addr_o(d1_addr), .dev_we_o(d1_we),
    .dev_be_o(d1_be), .dev_wdata_o(d1_wdata), .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata),
    .dev_err_i(dev_err), .spurious_o(d1_spur)
  );

  // exp bits: {dev_req, a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, spurious}
  typedef struct {
    bit       dut;
    bit       rst;
    bit       a, b, g, rv, er;
    bit [7:0] exp;
    bit       selb;
  } vec_t;

  vec_t vecs[$];
  bit   sb[$];   // expected owner of each outstanding transaction (1 = B)
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t v(bit dut, bit rst, bit a, bit b, bit g, bit rv, bit er,
                             bit [7:0] exp, bit selb);
    vec_t r;
    r.dut = dut; r.rst = rst; r.a = a; r.b = b; r.g = g; r.rv = rv; r.er = er;
    r.exp = exp; r.selb = selb;
    return r;
  endfunction

  function automatic bit [7:0] obs(bit dut);
    if (dut) return {d1_req, d1_a_gnt, d1_b_gnt, d1_a_rv, d1_b_rv, d1_a_err, d1_b_err, d1_spur};
    return {d0_req, d0_a_gnt, d0_b_gnt, d0_a_rv, d0_b_rv, d0_a_err, d0_b_err, d0_spur};
  endfunction

  task automatic drive(bit a, bit b, bit g, bit rv, bit er);
    a_req = a; b_req = b; dev_gnt = g; dev_rvalid = rv; dev_err = er;
    dev_rdata = $urandom;
  endtask

  task automatic do_reset(bit dut);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs(dut) !== 8'h00) begin
      failures++;
      $display("FAIL reset_state dut%0d: got %b want %b", dut, obs(dut), 8'h00);
    end
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic apply(int idx, vec_t r);
    bit [7:0]        got;
    logic [AW+1+DW/8+DW-1:0] fwd, want_fwd;
    bit              rva, rvb;
    drive(r.a, r.b, r.g, r.rv, r.er);
    #2;
    got = obs(r.dut);
    checks++;
    if (got !== r.exp) begin
      failures++;
      $display("FAIL vec%0d outputs: got %b want %b", idx, got, r.exp);
    end
    if (r.exp[7]) begin
      fwd      = r.dut ? {d1_addr, d1_we, d1_be, d1_wdata} : {d0_addr, d0_we, d0_be, d0_wdata};
      want_fwd = r.selb ? {B_ADDR, 1'b1, 4'h3, B_WDATA} : {A_ADDR, 1'b0, 4'hF, A_WDATA};
      checks++;
      if (fwd !== want_fwd) begin
        failures++;
        $display("FAIL vec%0d dev_mux: got %h want %h", idx, fwd, want_fwd);
      end
    end
    // Scoreboard: observed responses are matched against the expected owner
    // queue filled from the table's grant expectations.
    rva = r.dut ? d1_a_rv : d0_a_rv;
    rvb = r.dut ? d1_b_rv : d0_b_rv;
    if (rva || rvb) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL vec%0d sb_route: got rvalid a=%0b b=%0b want none", idx, rva, rvb);
      end else begin
        bit want_b;
        want_b = sb.pop_front();
        if (rvb !== want_b || rva !== !want_b) begin
          failures++;
          $display("FAIL vec%0d sb_route: got a=%0b b=%0b want b=%0b", idx, rva, rvb, want_b);
        end
      end
    end
    if (r.exp[6]) sb.push_back(1'b0);
    if (r.exp[5]) sb.push_back(1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);

    // A-only stream, 1-cycle device latency
    vecs.push_back(v(0,1, 1,0,1,0,0, 8'b1100_0000,0));
    for (int i = 0; i < 7; i++) vecs.push_back(v(0,0, 1,0,1,1,0, 8'b1101_0000,0));
    vecs.push_back(v(0,0, 0,0,0,1,0, 8'b0001_0000,0));
    // Round-robin contention: A,B,A,B,A,B
    vecs.push_back(v(0,1, 1,1,1,0,0, 8'b1100_0000,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(v(0,0, 1,1,1,1,0, (i % 2 == 0) ? 8'b1011_0000 : 8'b1100_1000, (i % 2 == 0)));
    vecs.push_back(v(0,0, 0,0,0,1,0, 8'b0000_1000,0));
    // Fixed priority B
    vecs.push_back(v(1,1, 1,1,1,0,0, 8'b1010_0000,1));
    vecs.push_back(v(1,0, 1,1,1,1,0, 8'b1010_1000,1));
    vecs.push_back(v(1,0, 1,1,1,1,0, 8'b1010_1000,1));
    vecs.push_back(v(1,0, 1,0,1,1,0, 8'b1100_1000,0));
    vecs.push_back(v(1,0, 0,0,0,1,0, 8'b0001_0000,0));
    // Backpressure at MaxOutstanding=2, then spurious response
    vecs.push_back(v(0,1, 1,0,1,0,0, 8'b1100_0000,0));
    vecs.push_back(v(0,0, 1,0,1,0,0, 8'b1100_0000,0));
    vecs.push_back(v(0,0, 1,0,1,0,0, 8'b0000_0000,0));
    vecs.push_back(v(0,0, 1,0,1,1,0, 8'b0001_0000,0));
    vecs.push_back(v(0,0, 1,0,1,0,0, 8'b1100_0000,0));
    vecs.push_back(v(0,0, 1,0,1,0,0, 8'b0000_0000,0));
    vecs.push_back(v(0,0, 0,0,0,1,0, 8'b0001_0000,0));
    vecs.push_back(v(0,0, 0,0,0,1,0, 8'b0001_0000,0));
    vecs.push_back(v(0,0, 0,0,0,1,0, 8'b0000_0000,0));
    vecs.push_back(v(0,0, 0,0,0,0,0, 8'b0000_0001,0));
    // Same-cycle push/pop and error routing
    vecs.push_back(v(0,1, 1,0,1,0,0, 8'b1100_0000,0));
    vecs.push_back(v(0,0, 0,1,1,1,1, 8'b1011_0100,1));
    vecs.push_back(v(0,0, 0,0,0,1,0, 8'b0000_1000,0));
    vecs.push_back(v(0,0, 0,1,1,0,0, 8'b1010_0000,1));
    vecs.push_back(v(0,0, 0,0,0,1,1, 8'b0000_1010,0));
    vecs.push_back(v(0,0, 0,0,0,0,0, 8'b0000_0000,0));
    // Spurious response, then fill to full ahead of a mid-flight reset
    vecs.push_back(v(0,1, 0,0,0,1,0, 8'b0000_0000,0));
    vecs.push_back(v(0,0, 0,0,0,0,0, 8'b0000_0001,0));
    vecs.push_back(v(0,0, 0,0,0,0,0, 8'b0000_0001,0));
    vecs.push_back(v(0,0, 1,1,1,0,0, 8'b1100_0001,0));
    vecs.push_back(v(0,0, 1,1,1,0,0, 8'b1010_0001,1));
    vecs.push_back(v(0,0, 1,1,1,0,0, 8'b0000_0001,0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        if (i > 0) begin
          checks++;
          if (sb.size() != 0) begin
            failures++;
            $display("FAIL vec%0d sb_drain: got %0d pending want 0", i, sb.size());
          end
        end
        do_reset(vecs[i].dut);
      end
      apply(i, vecs[i]);
    end

    // Asynchronous reset with two transactions outstanding and spurious set
    drive(1, 1, 1, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({d0_spur, d0_req, d0_a_gnt, d0_b_gnt} !== 4'b0110) begin
      failures++;
      $display("FAIL async_reset: got spur/req/agnt/bgnt=%b want 0110",
               {d0_spur, d0_req, d0_a_gnt, d0_b_gnt});
    end
    sb.delete();
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Late response to a pre-reset transaction
    drive(0, 0, 0, 1, 0);
    #2;
    checks++;
    if ({d0_a_rv, d0_b_rv, d0_spur} !== 3'b000) begin
      failures++;
      $display("FAIL late_resp: got arv/brv/spur=%b want 000", {d0_a_rv, d0_b_rv, d0_spur});
    end
    checks++;
    if (d0_a_rdata !== dev_rdata || d0_b_rdata !== dev_rdata) begin
      failures++;
      $display("FAIL rdata_pass: got %h/%h want %h", d0_a_rdata, d0_b_rdata, dev_rdata);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    #2;
    checks++;
    if (d0_spur !== 1'b1) begin
      failures++;
      $display("FAIL late_spurious: got %b want 1", d0_spur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one RAM port (req/gnt/rvalid protocol) between two hosts: port A (instruction fetch) and port B (data).
- Lets the simple system run on a single-port RAM, or free the second RAM port for DMA or debug.
- Arbitrates requests, forwards the winning request to the device, and tracks outstanding transactions in an ID FIFO so responses return to the correct host in order.

Parameters:
AddrWidth, 32, address width of hosts and device
DataWidth, 32, data width of hosts and device
MaxOutstanding, 2, maximum accepted-but-unanswered device transactions (1..4)
FixedPrioB, 0, 0 = round-robin between A and B; 1 = B always wins contention

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
a_req_i  in  1  host A request
a_gnt_o  out  1  host A grant
a_addr_i  in  AddrWidth  host A address
a_we_i  in  1  host A write enable
a_be_i  in  DataWidth/8  host A byte enables
a_wdata_i  in  DataWidth  host A write data
a_rvalid_o  out  1  host A response valid
a_rdata_o  out  DataWidth  host A read data
a_err_o  out  1  host A error
b_*  (same nine signals as a_*)  host B
dev_req_o  out  1  device request
dev_gnt_i  in  1  device grant
dev_addr_o  out  AddrWidth  device address
dev_we_o  out  1  device write enable
dev_be_o  out  DataWidth/8  device byte enables
dev_wdata_o  out  DataWidth  device write data
dev_rvalid_i  in  1  device response valid
dev_rdata_i  in  DataWidth  device read data
dev_err_i  in  1  device error
spurious_o  out  1  sticky flag: dev_rvalid_i received with no outstanding transaction

Behaviour:
- Reset values:
  - outstanding count = 0; ID FIFO empty.
  - last_winner = B, so A wins the first contention.
  - spurious_o = 0.
  - All *_gnt_o and *_rvalid_o = 0.
- full = (count == MaxOutstanding).
- Winner selection (combinational, same cycle):
  - Only one host requesting: that host wins.
  - Both requesting, FixedPrioB=1: B wins.
  - Both requesting, FixedPrioB=0: the host other than last_winner wins.
- dev_req_o = (a_req_i | b_req_i) & ~full.
- dev_addr/we/be/wdata_o are muxed from the winner. When no host is requesting they select A (don't-care).
- Winner's gnt_o = dev_gnt_i & dev_req_o. Loser's gnt_o = 0.
- full blocks new grants even if dev_rvalid_i arrives in the same cycle. This keeps the path from rvalid to gnt free of combinational logic.
- On handshake (dev_req_o & dev_gnt_i):
  - Push winner ID into the FIFO.
  - last_winner <= winner (updated only on handshake, never on a stalled request).
- On dev_rvalid_i with FIFO non-empty:
  - Pop the head ID.
  - Assert that host's rvalid_o in the same cycle (combinational pass-through, zero added latency).
  - Route dev_err_i to that host's err_o.
- rdata_o: both hosts receive dev_rdata_i unconditionally; rvalid_o qualifies it.
- Non-selected host: rvalid_o = 0 and err_o = 0.
- Handshake and response in the same cycle: push and pop both occur; count unchanged; FIFO order preserved (pop old head, push new tail).
- dev_rvalid_i with FIFO empty:
  - Ignored: no host rvalid, count stays 0.
  - spurious_o <= 1, held until reset.
- Count arithmetic:
  - Width = $clog2(MaxOutstanding+1).
  - Never exceeds MaxOutstanding and never underflows.
  - FIFO pointers wrap modulo MaxOutstanding.
- Hosts must hold req and attributes stable until gnt. The arbiter does not re-check this.
- A loser may keep requesting; it is granted on the next free handshake in round-robin mode.
- Reset asserted mid-transaction:
  - All state clears immediately (asynchronous).
  - Responses to pre-reset transactions arriving after reset are treated as spurious.

Test Plan:
- A-only stream: 8 reads, dev_gnt_i=1, device 1-cycle latency -> 8 a_gnt_o and 8 a_rvalid_o, each 1 cycle after its grant, b_rvalid_o never 1, count peaks at 1.
- Contention, FixedPrioB=0: both req held for 6 handshakes -> grant order A,B,A,B,A,B; responses route to the matching host in order.
- Contention, FixedPrioB=1: both req held -> B granted every cycle, A granted only after b_req_i drops.
- Backpressure: MaxOutstanding=2, device withholds rvalid -> 2 grants, then dev_req_o=0 while full. A single rvalid frees one slot -> exactly 1 further grant.
- Same-cycle push/pop at count=1: grant to B while rvalid returns for A -> a_rvalid_o=1, count stays 1, next rvalid goes to B. dev_err_i=1 on an A response -> a_err_o=1, b_err_o=0.
- Spurious and reset: dev_rvalid_i=1 with FIFO empty -> no host rvalid, spurious_o=1 next cycle and held. Assert rst_ni with count=2 -> count=0, spurious_o=0, last_winner=B.
